// File: rtl/pemstat_pkg.sv
// Shared definitions for the statistics carry controller.
// - Default sizing of the attached counter bank and host data path.
// - Host address map constants for the carry register (CAR) and carry mask (CAM).
// - Host access FSM state encoding.
package pemstat_pkg;

  localparam int DEF_NUM_CNT = 24;
  localparam int DEF_DATA_W  = 31;
  localparam int DEF_ADDR_W  = 5;

  // Register addresses directly follow the counter window.
  localparam int CAR_ADDR = DEF_NUM_CNT;
  localparam int CAM_ADDR = DEF_NUM_CNT + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CAPT = 3'd1,
    ST_CLR  = 3'd2,
    ST_WLD  = 3'd3,
    ST_ACK  = 3'd4
  } ctl_state_e;

endpackage

// File: rtl/pemstat_carry_bit.sv
// One carry bit: detects the rising overflow flag of a single counter,
// records it in the carry bit, requests the counter to drop its flag and
// honours host write-1-to-clear.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   ovf         sticky overflow flag from the counter
//   w1c         one-cycle host clear request for this carry bit
//   car         carry bit
//   ovf_clr     one-cycle overflow-flag clear strobe back to the counter
module pemstat_carry_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic ovf,
  input  logic w1c,
  output logic car,
  output logic ovf_clr
);

  logic pend_r;
  logic car_r;
  logic ovf_clr_r;
  logic capture_s;

  // A flag that is still high after being captured must not capture again.
  assign capture_s = ovf & ~pend_r;

  // Pending mirrors the flag level, so it drops once the counter clears its flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= 1'b0;
    end else begin
      pend_r <= ovf;
    end
  end

  // Carry bit; a new capture beats a simultaneous host clear so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_r <= 1'b0;
    end else if (capture_s) begin
      car_r <= 1'b1;
    end else if (w1c) begin
      car_r <= 1'b0;
    end else begin
      car_r <= car_r;
    end
  end

  // Flag-clear strobe, one cycle after the capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_clr_r <= 1'b0;
    end else begin
      ovf_clr_r <= capture_s;
    end
  end

  assign car     = car_r;
  assign ovf_clr = ovf_clr_r;

endmodule

// File: rtl/pemstat_carry_ctl.sv
// Statistics carry controller: serves host reads/writes of the counter
// bank, the carry register (CAR) and the carry mask (CAM), issues per-counter
// load / clear-on-read strobes and raises a maskable interrupt.
// Ports:
//   clk, rst_n             clock / async active-low reset
//   host_req/wr/addr/wdata host access request (held until host_ack)
//   clr_on_rd              counter read also clears the counter
//   host_ack, host_rdata   one-cycle completion pulse with read data
//   cnt_val, cnt_ovf       counter values and sticky overflow flags
//   cnt_load, cnt_ldata    one-hot counter load strobe and value
//   cnt_clr                one-hot counter clear strobe
//   cnt_ovf_clr            per-counter overflow-flag clear strobe
//   irq                    |(CAR & ~CAM), registered
module pemstat_carry_ctl
  import pemstat_pkg::*;
#(
  parameter int NUM_CNT = DEF_NUM_CNT,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      host_req,
  input  logic                      host_wr,
  input  logic [ADDR_W-1:0]         host_addr,
  input  logic [DATA_W-1:0]         host_wdata,
  input  logic                      clr_on_rd,
  output logic                      host_ack,
  output logic [DATA_W-1:0]         host_rdata,
  input  logic [NUM_CNT*DATA_W-1:0] cnt_val,
  input  logic [NUM_CNT-1:0]        cnt_ovf,
  output logic [NUM_CNT-1:0]        cnt_load,
  output logic [DATA_W-1:0]         cnt_ldata,
  output logic [NUM_CNT-1:0]        cnt_clr,
  output logic [NUM_CNT-1:0]        cnt_ovf_clr,
  output logic                      irq
);

  // Register addresses follow the counter window of this instance.
  localparam logic [ADDR_W-1:0] CAR_ADDR_C = ADDR_W'(NUM_CNT);
  localparam logic [ADDR_W-1:0] CAM_ADDR_C = ADDR_W'(NUM_CNT + 1);

  function automatic logic [NUM_CNT-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
    logic [NUM_CNT-1:0] oh;
    oh = {NUM_CNT{1'b0}};
    for (int i = 0; i < NUM_CNT; i++) begin
      oh[i] = (int'(a) == i);
    end
    return oh;
  endfunction

  ctl_state_e          state_r;
  ctl_state_e          next_state_s;
  logic [ADDR_W-1:0]   addr_r;
  logic                wr_r;
  logic                clr_r;
  logic [DATA_W-1:0]   rd_hold_r;
  logic [DATA_W-1:0]   rd_mux_s;
  logic [DATA_W-1:0]   cnt_sel_s;
  logic [NUM_CNT-1:0]  addr_oh_s;
  logic                addr_is_cnt_s;
  logic                accept_s;
  logic                wr_go_s;
  logic [NUM_CNT-1:0]  host_oh_s;
  logic [NUM_CNT-1:0]  w1c_s;
  logic [NUM_CNT-1:0]  car_s;
  logic [NUM_CNT-1:0]  cam_r;
  logic                host_ack_r;
  logic [DATA_W-1:0]   host_rdata_r;
  logic [NUM_CNT-1:0]  cnt_load_r;
  logic [DATA_W-1:0]   cnt_ldata_r;
  logic [NUM_CNT-1:0]  cnt_clr_r;
  logic                irq_r;

  assign accept_s      = (state_r == ST_IDLE) && host_req;
  assign wr_go_s       = accept_s && host_wr;
  assign host_oh_s     = addr_onehot(host_addr);
  assign addr_oh_s     = addr_onehot(addr_r);
  assign addr_is_cnt_s = |addr_oh_s;

  // Write effects are registered on the edge entering WLD, so CAR/CAM/load
  // all present their new values during the WLD cycle itself.
  assign w1c_s = (wr_go_s && (host_addr == CAR_ADDR_C)) ? host_wdata[NUM_CNT-1:0]
                                                        : {NUM_CNT{1'b0}};

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_carry
    pemstat_carry_bit u_carry_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .ovf     (cnt_ovf[g]),
      .w1c     (w1c_s[g]),
      .car     (car_s[g]),
      .ovf_clr (cnt_ovf_clr[g])
    );
  end

  // Read mux over counters, CAR and CAM; unmapped addresses read as zero.
  always_comb begin
    cnt_sel_s = {DATA_W{1'b0}};
    rd_mux_s  = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_sel_s = cnt_sel_s | (cnt_val[i*DATA_W +: DATA_W] & {DATA_W{addr_oh_s[i]}});
    end
    if (addr_is_cnt_s) begin
      rd_mux_s = cnt_sel_s;
    end else if (addr_r == CAR_ADDR_C) begin
      rd_mux_s[NUM_CNT-1:0] = car_s;
    end else if (addr_r == CAM_ADDR_C) begin
      rd_mux_s[NUM_CNT-1:0] = cam_r;
    end else begin
      rd_mux_s = {DATA_W{1'b0}};
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (host_req) begin
          next_state_s = host_wr ? ST_WLD : ST_CAPT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CAPT: begin
        if (addr_is_cnt_s && clr_r) begin
          next_state_s = ST_CLR;
        end else begin
          next_state_s = ST_ACK;
        end
      end
      ST_CLR:  next_state_s = ST_ACK;
      ST_WLD:  next_state_s = ST_ACK;
      ST_ACK:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Access attributes latched when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= {ADDR_W{1'b0}};
      wr_r   <= 1'b0;
      clr_r  <= 1'b0;
    end else if (accept_s) begin
      addr_r <= host_addr;
      wr_r   <= host_wr;
      clr_r  <= clr_on_rd;
    end else begin
      addr_r <= addr_r;
      wr_r   <= wr_r;
      clr_r  <= clr_r;
    end
  end

  // Read data is held in CAPT, before any clear strobe reaches the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_hold_r <= {DATA_W{1'b0}};
    end else if (state_r == ST_CAPT) begin
      rd_hold_r <= rd_mux_s;
    end else begin
      rd_hold_r <= rd_hold_r;
    end
  end

  // Carry mask; all counters masked out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_r <= {NUM_CNT{1'b1}};
    end else if (wr_go_s && (host_addr == CAM_ADDR_C)) begin
      cam_r <= host_wdata[NUM_CNT-1:0];
    end else begin
      cam_r <= cam_r;
    end
  end

  // Registered strobes and host response, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_load_r   <= {NUM_CNT{1'b0}};
      cnt_ldata_r  <= {DATA_W{1'b0}};
      cnt_clr_r    <= {NUM_CNT{1'b0}};
      host_ack_r   <= 1'b0;
      host_rdata_r <= {DATA_W{1'b0}};
    end else begin
      cnt_load_r  <= wr_go_s ? host_oh_s : {NUM_CNT{1'b0}};
      cnt_ldata_r <= (wr_go_s && (|host_oh_s)) ? host_wdata : {DATA_W{1'b0}};
      cnt_clr_r   <= (next_state_s == ST_CLR) ? addr_oh_s : {NUM_CNT{1'b0}};
      host_ack_r  <= (next_state_s == ST_ACK);
      if ((next_state_s == ST_ACK) && !wr_r) begin
        host_rdata_r <= (state_r == ST_CAPT) ? rd_mux_s : rd_hold_r;
      end else begin
        host_rdata_r <= {DATA_W{1'b0}};
      end
    end
  end

  // Interrupt follows CAR/CAM one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |(car_s & ~cam_r);
    end
  end

  assign host_ack   = host_ack_r;
  assign host_rdata = host_rdata_r;
  assign cnt_load   = cnt_load_r;
  assign cnt_ldata  = cnt_ldata_r;
  assign cnt_clr    = cnt_clr_r;
  assign irq        = irq_r;

endmodule

// File: tb/tb_pemstat_carry_ctl.sv
// Directed self-checking bench for pemstat_carry_ctl.
module tb_pemstat_carry_ctl;
  import pemstat_pkg::*;

  localparam int N  = 24;
  localparam int DW = 31;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            host_req = 1'b0;
  logic            host_wr = 1'b0;
  logic [AW-1:0]   host_addr = 5'd0;
  logic [DW-1:0]   host_wdata = 31'd0;
  logic            clr_on_rd = 1'b0;
  logic            host_ack;
  logic [DW-1:0]   host_rdata;
  logic [N*DW-1:0] cnt_val;
  logic [N-1:0]    cnt_ovf = 24'd0;
  logic [N-1:0]    cnt_load;
  logic [DW-1:0]   cnt_ldata;
  logic [N-1:0]    cnt_clr;
  logic [N-1:0]    cnt_ovf_clr;
  logic            irq;

  int tests_run = 0;
  int tests_failed = 0;

  // monitor state (written only by the monitor processes)
  int          cyc = 0;
  int          clr_tot = 0, load_tot = 0, oclr_tot = 0, ack_tot = 0;
  int          clr_cyc = 0, load_cyc = 0;
  logic [N-1:0]  clr_last = 24'd0, load_last = 24'd0, oclr_last = 24'd0;
  logic [DW-1:0] ldata_last = 31'd0;

  // access results (written only by host_access)
  logic [DW-1:0] acc_rdata;
  logic          acc_irq;
  int            acc_lat;
  int            acc_start;

  int clr0, load0, oclr0, ack0;

  pemstat_carry_ctl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host_req    (host_req),
    .host_wr     (host_wr),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .clr_on_rd   (clr_on_rd),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .cnt_val     (cnt_val),
    .cnt_ovf     (cnt_ovf),
    .cnt_load    (cnt_load),
    .cnt_ldata   (cnt_ldata),
    .cnt_clr     (cnt_clr),
    .cnt_ovf_clr (cnt_ovf_clr),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // strobe monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (cnt_clr != 24'd0) begin
      clr_tot  <= clr_tot + 1;
      clr_last <= cnt_clr;
      clr_cyc  <= cyc;
    end
    if (cnt_load != 24'd0) begin
      load_tot   <= load_tot + 1;
      load_last  <= cnt_load;
      ldata_last <= cnt_ldata;
      load_cyc   <= cyc;
    end
    if (cnt_ovf_clr != 24'd0) begin
      oclr_tot  <= oclr_tot + 1;
      oclr_last <= cnt_ovf_clr;
    end
    if (host_ack) ack_tot <= ack_tot + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One host access; latency counts the accepting cycle as cycle 1.
  task automatic host_access(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             input logic clr, input logic [N-1:0] ovf_set);
    bit got;
    @(negedge clk);
    host_req   = 1'b1;
    host_wr    = wr;
    host_addr  = addr;
    host_wdata = wd;
    clr_on_rd  = clr;
    cnt_ovf    = cnt_ovf | ovf_set;
    acc_start  = cyc;
    acc_rdata  = 31'h7ead_beef;
    acc_lat    = 0;
    acc_irq    = 1'bx;
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge clk);
      if (host_ack) begin
        got       = 1'b1;
        acc_rdata = host_rdata;
        acc_lat   = cyc - acc_start + 1;
        acc_irq   = irq;
      end
    end
    host_req  = 1'b0;
    host_wr   = 1'b0;
    clr_on_rd = 1'b0;
    if (!got) check_eq("ack_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic snap();
    clr0  = clr_tot;
    load0 = load_tot;
    oclr0 = oclr_tot;
    ack0  = ack_tot;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    cnt_val = {N*DW{1'b0}};
    for (int i = 0; i < N; i++) cnt_val[i*DW +: DW] = DW'(32'h1000 + i);
    cnt_val[5*DW +: DW] = 31'h123;
    cnt_val[9*DW +: DW] = 31'h7fff_ffff;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_ack",   32'(host_ack), 32'd0);
    check_eq("rst_rdata", 32'(host_rdata), 32'd0);
    check_eq("rst_load",  32'(cnt_load), 32'd0);
    check_eq("rst_ldata", 32'(cnt_ldata), 32'd0);
    check_eq("rst_clr",   32'(cnt_clr), 32'd0);
    check_eq("rst_oclr",  32'(cnt_ovf_clr), 32'd0);
    check_eq("rst_irq",   32'(irq), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    host_access(1'b0, AW'(CAR_ADDR), 31'd0, 1'b0, 24'd0);
    check_eq("car_rst", 32'(acc_rdata), 32'd0);
    check_eq("car_rd_lat", 32'(acc_lat), 32'd3);
    host_access(1'b0, AW'(CAM_ADDR), 31'd0, 1'b0, 24'd0);
    check_eq("cam_rst", 32'(acc_rdata), 32'h00ff_ffff);

    // read counter 5 with clear-on-read
    snap();
    host_access(1'b0, 5'd5, 31'd0, 1'b1, 24'd0);
    check_eq("rd5_data", 32'(acc_rdata), 32'h123);
    check_eq("rd5_lat", 32'(acc_lat), 32'd4);
    check_eq("rd5_clr_cnt", 32'(clr_tot - clr0), 32'd1);
    check_eq("rd5_clr_vec", 32'(clr_last), 32'h20);
    check_eq("rd5_clr_cyc", 32'(clr_cyc - acc_start + 1), 32'd3);
    check_eq("rd5_no_load", 32'(load_tot - load0), 32'd0);

    // read counter 9 at full scale, no clear
    snap();
    host_access(1'b0, 5'd9, 31'd0, 1'b0, 24'd0);
    check_eq("rd9_data", 32'(acc_rdata), 32'h7fff_ffff);
    check_eq("rd9_lat", 32'(acc_lat), 32'd3);
    check_eq("rd9_no_clr", 32'(clr_tot - clr0), 32'd0);

    // write counter 7
    snap();
    host_access(1'b1, 5'd7, 31'h0abc, 1'b0, 24'd0);
    check_eq("wr7_lat", 32'(acc_lat), 32'd3);
    check_eq("wr7_rdata", 32'(acc_rdata), 32'd0);
    check_eq("wr7_load_cnt", 32'(load_tot - load0), 32'd1);
    check_eq("wr7_load_vec", 32'(load_last), 32'h80);
    check_eq("wr7_ldata", 32'(ldata_last), 32'h0abc);
    check_eq("wr7_load_cyc", 32'(load_cyc - acc_start + 1), 32'd2);

    // unmask all, then overflow on counter 3 (flag held for a few cycles)
    host_access(1'b1, AW'(CAM_ADDR), 31'd0, 1'b0, 24'd0);
    check_eq("cam0_irq", 32'(acc_irq), 32'd0);
    snap();
    @(negedge clk);
    cnt_ovf[3] = 1'b1;
    repeat (3) @(negedge clk);
    cnt_ovf[3] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("ovf3_oclr_cnt", 32'(oclr_tot - oclr0), 32'd1);
    check_eq("ovf3_oclr_vec", 32'(oclr_last), 32'h8);
    check_eq("ovf3_irq", 32'(irq), 32'd1);
    host_access(1'b0, AW'(CAR_ADDR), 31'd0, 1'b0, 24'd0);
    check_eq("ovf3_car", 32'(acc_rdata), 32'h8);

    // W1C of CAR bit 3
    host_access(1'b1, AW'(CAR_ADDR), 31'h8, 1'b0, 24'd0);
    check_eq("w1c3_irq_ack", 32'(acc_irq), 32'd0);
    host_access(1'b0, AW'(CAR_ADDR), 31'd0, 1'b0, 24'd0);
    check_eq("w1c3_car", 32'(acc_rdata), 32'd0);

    // masked overflow on counter 0
    host_access(1'b1, AW'(CAM_ADDR), 31'h00ff_ffff, 1'b0, 24'd0);
    @(negedge clk);
    cnt_ovf[0] = 1'b1;
    repeat (3) @(negedge clk);
    cnt_ovf[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("mask_irq", 32'(irq), 32'd0);
    host_access(1'b0, AW'(CAR_ADDR), 31'd0, 1'b0, 24'd0);
    check_eq("mask_car", 32'(acc_rdata), 32'h1);
    check_eq("mask_irq_rd", 32'(acc_irq), 32'd0);
    host_access(1'b1, AW'(CAM_ADDR), 31'd0, 1'b0, 24'd0);
    check_eq("unmask_irq_ack", 32'(acc_irq), 32'd1);

    // collision: W1C of bits 0 and 2 while counter 2 overflows on the same edge
    host_access(1'b1, AW'(CAR_ADDR), 31'h5, 1'b0, 24'h4);
    cnt_ovf[2] = 1'b0;
    host_access(1'b0, AW'(CAR_ADDR), 31'd0, 1'b0, 24'd0);
    check_eq("coll_car", 32'(acc_rdata), 32'h4);
    check_eq("coll_irq", 32'(acc_irq), 32'd1);

    // unmapped write: ack, no load, registers untouched
    snap();
    host_access(1'b1, 5'd28, 31'h3ff, 1'b0, 24'd0);
    check_eq("unm_wr_rdata", 32'(acc_rdata), 32'd0);
    check_eq("unm_wr_load", 32'(load_tot - load0), 32'd0);
    host_access(1'b0, AW'(CAM_ADDR), 31'd0, 1'b0, 24'd0);
    check_eq("unm_wr_cam", 32'(acc_rdata), 32'd0);

    // reset during CLR
    @(negedge clk);
    host_req  = 1'b1;
    host_wr   = 1'b0;
    host_addr = 5'd5;
    clr_on_rd = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (cnt_clr != 24'd0) seen = 1'b1;
    end
    if (!seen) check_eq("midrst_no_clr", 32'd0, 32'd1);
    rst_n = 1'b0;
    #1;
    snap();
    check_eq("midrst_clr", 32'(cnt_clr), 32'd0);
    check_eq("midrst_load", 32'(cnt_load), 32'd0);
    check_eq("midrst_ack", 32'(host_ack), 32'd0);
    check_eq("midrst_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    host_req  = 1'b0;
    clr_on_rd = 1'b0;
    rst_n     = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("midrst_no_ack", 32'(ack_tot - ack0), 32'd0);

    host_access(1'b0, 5'd31, 31'd0, 1'b0, 24'd0);
    check_eq("rd31_data", 32'(acc_rdata), 32'd0);
    check_eq("rd31_lat", 32'(acc_lat), 32'd3);
    host_access(1'b0, AW'(CAM_ADDR), 31'd0, 1'b0, 24'd0);
    check_eq("post_rst_cam", 32'(acc_rdata), 32'h00ff_ffff);
    host_access(1'b0, AW'(CAR_ADDR), 31'd0, 1'b0, 24'd0);
    check_eq("post_rst_car", 32'(acc_rdata), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
